// File: rtl/inet_csum_pkg.sv
// inet_csum_pkg: shared types, IPv4 constants and one's-complement helpers for the checksum datapath
package inet_csum_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FOLD, ST_OUT} state_t;
  localparam logic [15:0] IPV4_VER_IHL_TOS = 16'h4500;
  localparam logic [7:0] IPV4_TTL_DEFAULT = 8'h80;
  localparam logic [7:0] PROTO_UDP = 8'h11;
  localparam logic [7:0] PROTO_TCP = 8'h06;
  function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
  function automatic logic [15:0] pseudo_seed(input logic [31:0] src, input logic [31:0] dst,
                                             input logic [7:0] proto, input logic [15:0] len);
    logic [15:0] s;
    s = csum_add16(src[31:16], src[15:0]);
    s = csum_add16(s, dst[31:16]);
    s = csum_add16(s, dst[15:0]);
    s = csum_add16(s, {8'h00, proto});
    return csum_add16(s, len);
  endfunction
endpackage

// File: rtl/inet_csum_stream_if.sv
// inet_csum_stream_if: byte-stream input and checksum result handshakes of the checksum engine
interface inet_csum_stream_if #(parameter int DATA_BYTES = 4);
  logic [15:0] seed;
  logic s_valid;
  logic s_ready;
  logic [8*DATA_BYTES-1:0] s_data;
  logic [DATA_BYTES-1:0] s_keep;
  logic s_last;
  logic m_valid;
  logic m_ready;
  logic [15:0] m_csum;
  logic [15:0] m_len;
  modport master (output seed, s_valid, s_data, s_keep, s_last, m_ready,
                  input s_ready, m_valid, m_csum, m_len);
  modport slave (input seed, s_valid, s_data, s_keep, s_last, m_ready,
                 output s_ready, m_valid, m_csum, m_len);
endinterface

// File: rtl/inet_csum_fold.sv
// inet_csum_fold: two-stage carry fold, inversion and result holding register
// INET_CSUM_UDP_ZERO_FIX_EN: report a 0x0000 checksum as 0xFFFF
module inet_csum_fold #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] acc,
  input  logic [15:0]      len,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [15:0]      m_csum,
  output logic [15:0]      m_len
);
  logic [16:0] f1;
  logic        v1;
  logic [15:0] f2;
  logic [15:0] csum_n;
  always_comb begin
    f2 = f1[15:0] + {15'd0, f1[16]};
`ifdef INET_CSUM_UDP_ZERO_FIX_EN
    csum_n = (~f2 == 16'h0000) ? 16'hFFFF : ~f2;
`else
    csum_n = ~f2;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f1 <= '0;
      v1 <= 1'b0;
      m_valid <= 1'b0;
      m_csum <= '0;
      m_len <= '0;
    end else begin
      v1 <= start;
      if (start) f1 <= {1'b0, acc[15:0]} + 17'(acc[ACC_W-1:16]);
      if (v1) begin
        m_valid <= 1'b1;
        m_csum <= csum_n;
        m_len <= len;
      end else if (m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/inet_csum_stream.sv
// inet_csum_stream: seeded RFC 1071 checksum and byte count over a keep-qualified byte stream
// INET_CSUM_UDP_ZERO_FIX_EN (in inet_csum_fold): UDP zero-checksum substitution
module inet_csum_stream
  import inet_csum_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst_n,
  inet_csum_stream_if.slave bus
);
  localparam int WORDS = DATA_BYTES / 2;
  localparam int SUM_W = 16 + $clog2(WORDS);
  localparam int CNT_W = $clog2(DATA_BYTES + 1);
  state_t state, state_n;
  logic fold_cnt;
  logic [ACC_W-1:0] acc;
  logic [15:0] len;
  logic [8*DATA_BYTES-1:0] masked;
  logic [SUM_W-1:0] beat_sum;
  logic [CNT_W-1:0] beat_len;
  logic [16:0] len_sum;
  logic accept, first, m_valid;
  assign bus.s_ready = rst_n && (state == ST_IDLE || state == ST_ACC);
  assign accept = bus.s_valid && bus.s_ready;
  assign first = state == ST_IDLE;
  assign bus.m_valid = m_valid;
  always_comb begin
    masked = '0;
    beat_len = '0;
    beat_sum = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      masked[8*j +: 8] = bus.s_data[8*j +: 8] & {8{bus.s_keep[j]}};
      beat_len = beat_len + CNT_W'(bus.s_keep[j]);
    end
    for (int w = 0; w < WORDS; w++) beat_sum = beat_sum + SUM_W'(masked[16*w +: 16]);
    len_sum = 17'(first ? 16'd0 : len) + 17'(beat_len);
  end
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: state_n = accept ? (bus.s_last ? ST_FOLD : ST_ACC) : ST_IDLE;
      ST_ACC:  state_n = (accept && bus.s_last) ? ST_FOLD : ST_ACC;
      ST_FOLD: state_n = fold_cnt ? ST_OUT : ST_FOLD;
      ST_OUT:  state_n = (m_valid && bus.m_ready) ? ST_IDLE : ST_OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      fold_cnt <= 1'b0;
      acc <= '0;
      len <= '0;
    end else begin
      state <= state_n;
      fold_cnt <= (state == ST_FOLD) && !fold_cnt;
      if (accept) begin
        acc <= (first ? ACC_W'(bus.seed) : acc) + ACC_W'(beat_sum);
        len <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
      end
    end
  end
  inet_csum_fold #(.ACC_W(ACC_W)) u_fold (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (state == ST_FOLD && !fold_cnt),
    .acc     (acc),
    .len     (len),
    .m_ready (bus.m_ready),
    .m_valid (m_valid),
    .m_csum  (bus.m_csum),
    .m_len   (bus.m_len)
  );
endmodule

// File: tb/tb_inet_csum_stream.sv
// tb_inet_csum_stream: directed and random packets against an arithmetic RFC 1071 reference
module tb_inet_csum_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pkt[$];
  inet_csum_stream_if #(.DATA_BYTES(4)) bus ();
  inet_csum_stream #(.DATA_BYTES(4), .ACC_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] sd);
    int unsigned s;
    logic [7:0] lo;
    logic [15:0] r;
    s = 32'(sd);
    for (int i = 0; i < pkt.size(); i += 2) begin
      lo = (i + 1 < pkt.size()) ? pkt[i+1] : 8'h00;
      s += 32'({pkt[i], lo});
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    r = ~s[15:0];
`ifdef INET_CSUM_UDP_ZERO_FIX_EN
    if (r == 16'h0000) r = 16'hFFFF;
`endif
    return r;
  endfunction

  task automatic run_pkt(input logic [15:0] sd, input logic [15:0] exp_csum, input logic [15:0] exp_len,
                         input int bp, input bit rand_gap, input bit extra_empty, input int stop_at);
    int n, nb, idx, guard;
    logic [31:0] data;
    logic [3:0] keep;
    n = pkt.size();
    nb = (n + 3) / 4;
    if (nb == 0 || (extra_empty && n % 4 == 0)) nb++;
    for (int b = 0; b < nb; b++) begin
      if (b == stop_at) begin
        bus.s_valid = 1'b0;
        return;
      end
      if (rand_gap && $urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        step();
      end
      data = $urandom;
      keep = '0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * b + k;
        if (idx < n) begin
          data[31-8*k -: 8] = pkt[idx];
          keep[3-k] = 1'b1;
        end
      end
      bus.s_data = data;
      bus.s_keep = keep;
      bus.s_last = (b == nb - 1);
      bus.seed = (b == 0) ? sd : 16'($urandom);
      bus.s_valid = 1'b1;
      guard = 0;
      while (!bus.s_ready && guard < 20) begin
        step();
        guard++;
      end
      if (guard == 20) chk("s_ready timeout", {31'd0, bus.s_ready}, 32'd1);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    chk("m_valid N+1", {31'd0, bus.m_valid}, 32'd0);
    chk("s_ready fold", {31'd0, bus.s_ready}, 32'd0);
    step();
    chk("m_valid N+2", {31'd0, bus.m_valid}, 32'd0);
    step();
    chk("m_valid N+3", {31'd0, bus.m_valid}, 32'd1);
    chk("m_csum", {16'd0, bus.m_csum}, {16'd0, exp_csum});
    chk("m_len", {16'd0, bus.m_len}, {16'd0, exp_len});
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp m_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("bp s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("bp m_csum", {16'd0, bus.m_csum}, {16'd0, exp_csum});
      chk("bp m_len", {16'd0, bus.m_len}, {16'd0, exp_len});
    end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("post m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("post s_ready", {31'd0, bus.s_ready}, 32'd1);
  endtask

  task automatic load_ipv4();
    logic [7:0] hdr[20];
    hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    pkt.delete();
    foreach (hdr[i]) pkt.push_back(hdr[i]);
  endtask

  initial begin
    int n;
    logic [15:0] sd;
    logic [15:0] zero_exp;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_keep = '0;
    bus.s_last = 1'b0;
    bus.seed = '0;
    bus.m_ready = 1'b0;
    step();
    step();
    chk("rst s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst m_csum", {16'd0, bus.m_csum}, 32'd0);
    chk("rst m_len", {16'd0, bus.m_len}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel s_ready", {31'd0, bus.s_ready}, 32'd1);
    load_ipv4();
    run_pkt(16'h0000, 16'hB861, 16'd20, 0, 1'b0, 1'b0, -1);
    pkt = '{8'h01, 8'h02, 8'h03};
    run_pkt(16'h0000, 16'hFBFD, 16'd3, 0, 1'b0, 1'b0, -1);
    pkt = '{8'hFF, 8'hFF};
    run_pkt(16'h0001, 16'hFFFE, 16'd2, 0, 1'b0, 1'b0, -1);
`ifdef INET_CSUM_UDP_ZERO_FIX_EN
    zero_exp = 16'hFFFF;
`else
    zero_exp = 16'h0000;
`endif
    run_pkt(16'h0000, zero_exp, 16'd2, 0, 1'b0, 1'b0, -1);
    load_ipv4();
    run_pkt(16'h0000, 16'hB861, 16'd20, 10, 1'b0, 1'b0, -1);
    pkt = '{8'hFF, 8'hFF};
    run_pkt(16'h0001, 16'hFFFE, 16'd2, 0, 1'b0, 1'b0, -1);
    pkt.delete();
    run_pkt(16'h1234, 16'hEDCB, 16'd0, 0, 1'b0, 1'b0, -1);
    load_ipv4();
    run_pkt(16'h0000, 16'h0000, 16'd0, 0, 1'b0, 1'b0, 2);
    rst_n = 1'b0;
    step();
    chk("midrst s_ready", {31'd0, bus.s_ready}, 32'd0);
    step();
    chk("midrst m_valid", {31'd0, bus.m_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle m_valid", {31'd0, bus.m_valid}, 32'd0);
    end
    run_pkt(16'h0000, 16'hB861, 16'd20, 0, 1'b0, 1'b0, -1);
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 64);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      sd = 16'($urandom);
      run_pkt(sd, model_csum(sd), 16'(n), $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
